// File: rtl/multi_channel_pwm.sv
// -----------------------------------------------------------------------------
// multi_channel_pwm
//
// Purpose:
//   CHANNELS independent PWM outputs driven from one shared period counter.
//   Period and duty values are written into shadow registers by a one-cycle
//   load strobe. They are copied into the active registers only when the
//   counter wraps, so a change never produces a glitch or a runt pulse.
//
// Configuration macro:
//   PWM_CENTER_ALIGNED_EN - when defined, the counter runs up and then down
//                           (centre-aligned PWM) and a direction register is
//                           added. When undefined, the counter is an
//                           edge-aligned up-counter.
//
// Parameters:
//   CHANNELS        number of PWM outputs (1..16)
//   WIDTH           width of period, duty and counter (2..16)
//   DEFAULT_PERIOD  active period loaded at reset
//
// Ports:
//   clock           system clock; all logic is on the rising edge
//   reset           synchronous, active-high reset
//   period          counter maximum for the next update (period+1 cycles)
//   duty            per-channel high time; channel i uses [i*WIDTH +: WIDTH]
//   load            strobe that captures period/duty into the shadow registers
//   update_pending  high while shadow values wait for a period boundary
//   period_start    one-cycle strobe on the first cycle of each period
//   pulse           registered PWM outputs
// -----------------------------------------------------------------------------
module multi_channel_pwm #(
  parameter int CHANNELS       = 4,
  parameter int WIDTH          = 8,
  parameter int DEFAULT_PERIOD = 255
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  input  logic                      load,
  output logic                      update_pending,
  output logic                      period_start,
  output logic [CHANNELS-1:0]       pulse
);

  localparam logic [WIDTH-1:0] P_DEFAULT = WIDTH'(DEFAULT_PERIOD);

  logic [WIDTH-1:0]    r_count;
  logic [WIDTH-1:0]    r_active_period;
  logic [WIDTH-1:0]    r_shadow_period;
  logic [WIDTH-1:0]    r_active_duty [CHANNELS];
  logic [WIDTH-1:0]    r_shadow_duty [CHANNELS];
  logic                r_update_pending;
  logic                r_period_start;
  logic [CHANNELS-1:0] r_pulse;

  logic [WIDTH-1:0]    w_count_next;
  logic                w_wrap;

`ifdef PWM_CENTER_ALIGNED_EN
  logic r_dir_down;
  logic w_dir_down_next;

  // Up 0..active_period, then down active_period-1..1, then back to 0.
  // The wrap is the cycle whose successor is count 0, so new values take
  // effect exactly when the next period starts at count 0.
  // NOTE: every signal written in always_comb gets a default first so that no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_count_next    = '0;
    w_dir_down_next = r_dir_down;
    if (!r_dir_down) begin
      if (r_count < r_active_period) begin
        w_count_next = r_count + WIDTH'(1);
      end else if (r_active_period > WIDTH'(1)) begin
        w_count_next    = r_active_period - WIDTH'(1);
        w_dir_down_next = 1'b1;
      end else begin
        // active_period of 0 holds at 0; active_period of 1 gives 0,1,0,1.
        w_count_next    = '0;
        w_dir_down_next = 1'b0;
      end
    end else begin
      if (r_count > WIDTH'(1)) begin
        w_count_next = r_count - WIDTH'(1);
      end else begin
        w_count_next    = '0;
        w_dir_down_next = 1'b0;
      end
    end
    w_wrap = (w_count_next == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_dir_down <= 1'b0;
    end else begin
      r_dir_down <= w_dir_down_next;
    end
  end
`else
  always_comb begin
    w_wrap       = (r_count == r_active_period);
    w_count_next = w_wrap ? '0 : r_count + WIDTH'(1);
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count          <= '0;
      r_active_period  <= P_DEFAULT;
      r_shadow_period  <= P_DEFAULT;
      r_update_pending <= 1'b0;
      r_period_start   <= 1'b0;
      r_pulse          <= '0;
      // NOTE: the duty arrays are real state with defined reset values (zero
      // duty means outputs low), so they are reset here rather than left as
      // uninitialised storage.
      for (int i = 0; i < CHANNELS; i++) begin
        r_active_duty[i] <= '0;
        r_shadow_duty[i] <= '0;
      end
    end else begin
      r_count        <= w_count_next;
      r_period_start <= (r_count == '0);
      for (int i = 0; i < CHANNELS; i++) begin
        r_pulse[i] <= (r_count < r_active_duty[i]);
      end

      if (load && w_wrap) begin
        // A load on the boundary bypasses the shadow wait entirely.
        r_active_period  <= period;
        r_shadow_period  <= period;
        r_update_pending <= 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
          r_active_duty[i] <= duty[i*WIDTH +: WIDTH];
          r_shadow_duty[i] <= duty[i*WIDTH +: WIDTH];
        end
      end else if (load) begin
        // Later loads overwrite earlier ones; only the last one is applied.
        r_shadow_period  <= period;
        r_update_pending <= 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
          r_shadow_duty[i] <= duty[i*WIDTH +: WIDTH];
        end
      end else if (w_wrap && r_update_pending) begin
        r_active_period  <= r_shadow_period;
        r_update_pending <= 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
          r_active_duty[i] <= r_shadow_duty[i];
        end
      end
    end
  end

  assign update_pending = r_update_pending;
  assign period_start   = r_period_start;
  assign pulse          = r_pulse;

endmodule

// File: tb/tb_multi_channel_pwm.sv
// -----------------------------------------------------------------------------
// tb_multi_channel_pwm
//
// Directed bench for multi_channel_pwm in its default (edge-aligned) build,
// with CHANNELS=4, WIDTH=8 and DEFAULT_PERIOD=9. Inputs change 1 time unit
// after a rising edge and outputs are sampled at the same point. The step
// task accumulates per-channel high cycles, period_start strobes and
// update_pending cycles so that whole periods can be compared against
// hand-computed totals.
// -----------------------------------------------------------------------------
module tb_multi_channel_pwm;

  localparam int CHANNELS = 4;
  localparam int WIDTH    = 8;

  logic                      clock = 1'b0;
  logic                      reset;
  logic [WIDTH-1:0]          period;
  logic [CHANNELS*WIDTH-1:0] duty;
  logic                      load;
  logic                      update_pending;
  logic                      period_start;
  logic [CHANNELS-1:0]       pulse;

  int n_checks = 0;
  int n_fail   = 0;
  int acc_hi [CHANNELS];
  int acc_ps;
  int acc_pend;

  multi_channel_pwm #(
    .CHANNELS      (CHANNELS),
    .WIDTH         (WIDTH),
    .DEFAULT_PERIOD(9)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .period        (period),
    .duty          (duty),
    .load          (load),
    .update_pending(update_pending),
    .period_start  (period_start),
    .pulse         (pulse)
  );

  always #5 clock = ~clock;

  function automatic logic [CHANNELS*WIDTH-1:0] mk_duty(
    input logic [WIDTH-1:0] d3, input logic [WIDTH-1:0] d2,
    input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic clear_acc();
    for (int i = 0; i < CHANNELS; i++) acc_hi[i] = 0;
    acc_ps   = 0;
    acc_pend = 0;
  endtask

  // Advance n rising edges; sample outputs 1 time unit after each edge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
      for (int i = 0; i < CHANNELS; i++) acc_hi[i] += int'(pulse[i]);
      acc_ps   += int'(period_start);
      acc_pend += int'(update_pending);
    end
  endtask

  initial begin
    reset  = 1'b1;
    load   = 1'b0;
    period = '0;
    duty   = '0;
    clear_acc();

    // Reset state.
    step(2);
    check("reset_pulse", 32'(pulse), 32'd0);
    check("reset_pending", 32'(update_pending), 32'd0);
    check("reset_period_start", 32'(period_start), 32'd0);

    // Release: the count==0 cycle comes first, period_start follows it.
    reset = 1'b0;
    step(1);                                    // edge 1 (count 0)
    check("first_period_start", 32'(period_start), 32'd1);
    check("default_duty_low", 32'(pulse), 32'd0);

    // Load on the wrap of the default period (count 9 before edge 10).
    step(8);                                    // edges 2..9
    load   = 1'b1;
    period = 8'd9;
    duty   = mk_duty(8'd9, 8'd10, 8'd0, 8'd3);
    step(1);                                    // edge 10, wrap
    load = 1'b0;
    check("wrap_load_no_pending", 32'(update_pending), 32'd0);

    clear_acc();
    step(1);                                    // edge 11 (count 0)
    check("first_cycle_pulses", 32'(pulse), 32'b1101);
    step(9);                                    // edges 12..20
    check("t1_ch0_high", 32'(acc_hi[0]), 32'd3);
    check("t1_ch1_never", 32'(acc_hi[1]), 32'd0);
    check("t1_ch2_always", 32'(acc_hi[2]), 32'd10);
    check("t1_ch3_high", 32'(acc_hi[3]), 32'd9);
    check("t1_period_start", 32'(acc_ps), 32'd1);
    check("t1_pending", 32'(acc_pend), 32'd0);
    clear_acc();
    step(10);                                   // edges 21..30
    check("t1b_ch0_high", 32'(acc_hi[0]), 32'd3);
    check("t1b_period_start", 32'(acc_ps), 32'd1);

    // Mid-period load at count 4: current period keeps duty 3.
    clear_acc();
    step(4);                                    // edges 31..34
    load = 1'b1;
    duty = mk_duty(8'd9, 8'd10, 8'd0, 8'd7);
    step(1);                                    // edge 35 (count 4)
    load = 1'b0;
    check("t2_pending_set", 32'(update_pending), 32'd1);
    step(4);                                    // edges 36..39
    check("t2_pending_hold", 32'(update_pending), 32'd1);
    step(1);                                    // edge 40, wrap
    check("t2_pending_clear", 32'(update_pending), 32'd0);
    check("t2_old_duty", 32'(acc_hi[0]), 32'd3);
    check("t2_pending_cycles", 32'(acc_pend), 32'd5);
    clear_acc();
    step(10);                                   // edges 41..50
    check("t2_new_duty", 32'(acc_hi[0]), 32'd7);
    check("t2_no_pending", 32'(acc_pend), 32'd0);

    // Two loads in one period: the later one wins.
    clear_acc();
    step(2);                                    // edges 51..52
    load = 1'b1;
    duty = mk_duty(8'd9, 8'd10, 8'd0, 8'd2);
    step(1);                                    // edge 53 (count 2)
    load = 1'b0;
    check("t3_pending_first", 32'(update_pending), 32'd1);
    step(3);                                    // edges 54..56
    load = 1'b1;
    duty = mk_duty(8'd9, 8'd10, 8'd0, 8'd5);
    step(1);                                    // edge 57 (count 6)
    load = 1'b0;
    step(2);                                    // edges 58..59
    check("t3_pending_second", 32'(update_pending), 32'd1);
    step(1);                                    // edge 60, wrap
    check("t3_pending_clear", 32'(update_pending), 32'd0);
    check("t3_pending_cycles", 32'(acc_pend), 32'd7);
    check("t3_old_duty", 32'(acc_hi[0]), 32'd7);
    clear_acc();
    step(10);                                   // edges 61..70
    check("t3_last_load_wins", 32'(acc_hi[0]), 32'd5);

    // Load exactly on the wrap with period 4: next period is 5 cycles.
    step(9);                                    // edges 71..79
    load   = 1'b1;
    period = 8'd4;
    duty   = mk_duty(8'd9, 8'd10, 8'd0, 8'd2);
    step(1);                                    // edge 80, wrap
    load = 1'b0;
    check("t4_no_pending", 32'(update_pending), 32'd0);
    clear_acc();
    step(1);                                    // edge 81 (count 0)
    check("t4_ps_first", 32'(period_start), 32'd1);
    step(4);                                    // edges 82..85
    check("t4_ps_mid", 32'(period_start), 32'd0);
    step(1);                                    // edge 86 (count 0)
    check("t4_ps_second", 32'(period_start), 32'd1);
    step(4);                                    // edges 87..90
    check("t4_ps_count", 32'(acc_ps), 32'd2);
    check("t4_ch0_high", 32'(acc_hi[0]), 32'd4);
    check("t4_ch1_never", 32'(acc_hi[1]), 32'd0);
    check("t4_ch2_always", 32'(acc_hi[2]), 32'd10);
    check("t4_ch3_above_period", 32'(acc_hi[3]), 32'd10);
    check("t4_pending_never", 32'(acc_pend), 32'd0);

    // Back to period 9 via a wrap load (count 4 before edge 95).
    step(4);                                    // edges 91..94
    load   = 1'b1;
    period = 8'd9;
    duty   = mk_duty(8'd9, 8'd10, 8'd0, 8'd3);
    step(1);                                    // edge 95, wrap
    load = 1'b0;

    // Pending load, then reset for one cycle at count 6.
    step(2);                                    // edges 96..97
    load = 1'b1;
    duty = mk_duty(8'd9, 8'd10, 8'd0, 8'd8);
    step(1);                                    // edge 98 (count 2)
    load = 1'b0;
    check("t5_pending_before_reset", 32'(update_pending), 32'd1);
    step(3);                                    // edges 99..101
    reset = 1'b1;
    step(1);                                    // edge 102 (count 6), reset
    reset = 1'b0;
    check("t5_reset_pulse", 32'(pulse), 32'd0);
    check("t5_reset_pending", 32'(update_pending), 32'd0);
    check("t5_reset_ps", 32'(period_start), 32'd0);
    clear_acc();
    step(1);                                    // edge 103 (count 0)
    check("t5_restart_ps", 32'(period_start), 32'd1);
    step(9);                                    // edges 104..112
    check("t5_ps_once", 32'(acc_ps), 32'd1);
    check("t5_update_lost", 32'(acc_hi[0] + acc_hi[1] + acc_hi[2] + acc_hi[3]), 32'd0);
    check("t5_pending_never", 32'(acc_pend), 32'd0);
    step(1);                                    // edge 113 (count 0)
    check("t5_default_period", 32'(period_start), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
